sys_reset_sequencer: RTL and testbench
======================================

SYS_RESET_SEQUENCER -- requirements
Module: sys_reset_sequencer

Interface
REQ-001 SHALL have parameter LOCK_SETTLE_CYCLES, default 1024: consecutive synchronized-lock cycles required before IDELAY reset.
REQ-002 SHALL have parameter IDELAY_RST_CYCLES, default 16: width of the idelay_rst pulse.
REQ-003 SHALL have parameter RDY_TIMEOUT, default 4096: maximum WAIT_RDY cycles per attempt.
REQ-004 SHALL have parameter MAX_RETRIES, default 3: maximum re-pulses after timeout before FAIL.
REQ-005 SHALL have one clock and a synchronous, active-low reset.
REQ-006 SHALL have port sys_clk, input, 1: sole clock, all logic rising-edge.
REQ-007 SHALL have port sys_rst_n, input, 1: synchronous active-low reset.
REQ-008 SHALL have port sys_clk_lock, input, 1: clock-manager lock, asynchronous.
REQ-009 SHALL have port idelay_rdy, input, 1: IDELAYCTRL ready, asynchronous.
REQ-010 SHALL have port soft_rst, input, 1: single-cycle software restart request.
REQ-011 SHALL have port idelay_rst, output, 1: active-high IDELAYCTRL reset.
REQ-012 SHALL have port user_rst, output, 1: active-high reset to the user design.
REQ-013 SHALL have port seq_ready, output, 1: sequencer in RUN.
REQ-014 SHALL have port seq_fail, output, 1: sequencer in FAIL.
REQ-015 SHALL have port seq_state, output, 3: current state encoding.
REQ-016 SHALL have port retry_cnt, output, 2: retries consumed in the current bring-up.
REQ-017 SHALL have port lock_loss_cnt, output, 8: saturating count of lock losses.

Function
REQ-018 SHALL synchronize sys_clk_lock and idelay_rdy through two flops each (lock_s, rdy_s); FSM SHALL use only lock_s and rdy_s.
REQ-019 SHALL implement states WAIT_LOCK=0, SETTLE=1, IDLY_RST=2, WAIT_RDY=3, RUN=4, FAIL=5.
REQ-020 SHALL transition WAIT_LOCK -> SETTLE when lock_s=1, clearing the cycle counter.
REQ-021 SHALL count cycles in SETTLE and enter IDLY_RST on the cycle the count equals LOCK_SETTLE_CYCLES-1.
REQ-022 SHALL hold IDLY_RST for exactly IDELAY_RST_CYCLES cycles, then enter WAIT_RDY with the counter cleared.
REQ-023 SHALL, in WAIT_RDY, enter RUN when rdy_s=1; on count RDY_TIMEOUT-1 with rdy_s=0, SHALL increment retry_cnt and enter IDLY_RST if retry_cnt<MAX_RETRIES, else enter FAIL.
REQ-024 SHALL give rdy_s=1 priority over timeout in the same cycle.
REQ-025 SHALL, on lock_s=0 in SETTLE, IDLY_RST, WAIT_RDY or RUN, enter WAIT_LOCK, clear retry_cnt, and increment lock_loss_cnt saturating at 255.
REQ-026 SHALL leave FAIL only via sys_rst_n=0 or soft_rst=1; lock loss SHALL NOT exit FAIL.
REQ-027 SHALL, on soft_rst=1 in SETTLE, IDLY_RST, WAIT_RDY, RUN or FAIL, clear retry_cnt and enter IDLY_RST with the counter cleared; soft_rst SHALL be ignored in WAIT_LOCK.
REQ-028 SHALL give lock loss priority over soft_rst in the same cycle.
REQ-029 SHALL register all outputs: idelay_rst=1 iff state is IDLY_RST; user_rst=0 iff state is RUN; seq_ready=1 iff RUN; seq_fail=1 iff FAIL; all valid in the cycle after the state update.
REQ-030 SHALL size internal counters to hold the largest of the three cycle parameters, with no wrap before compare.

Reset
REQ-031 SHALL, while sys_rst_n=0 at a clock edge, set state WAIT_LOCK, sync flops 0, counter 0, retry_cnt 0, lock_loss_cnt 0, idelay_rst 0, user_rst 1, seq_ready 0, seq_fail 0, seq_state 0.
REQ-032 SHALL abort any in-progress sequence on reset mid-operation, dropping idelay_rst to 0 at the same edge.

Verification (bench parameters LOCK_SETTLE_CYCLES=8, IDELAY_RST_CYCLES=4, RDY_TIMEOUT=16, MAX_RETRIES=2)
REQ-033 SHALL cover nominal bring-up: lock=1 at cycle 0, rdy=1 after idelay_rst falls -> idelay_rst high exactly 4 cycles, user_rst falls, seq_state=4.
REQ-034 SHALL cover timeout path: rdy held 0 -> three idelay_rst pulses, retry_cnt 1 then 2, then seq_fail=1, seq_state=5, user_rst=1.
REQ-035 SHALL cover lock loss in RUN: lock drops 1 cycle -> seq_state=0, user_rst=1, lock_loss_cnt=1; relock re-sequences fully.
REQ-036 SHALL cover lock loss and soft_rst in the same cycle in WAIT_RDY -> WAIT_LOCK, not IDLY_RST.
REQ-037 SHALL cover soft_rst in FAIL -> IDLY_RST, retry_cnt=0; and sys_rst_n=0 during IDLY_RST -> all outputs at REQ-031 values next edge.
REQ-038 SHALL cover 300 lock losses -> lock_loss_cnt saturates at 255.

Source files
------------

// File: rtl/sys_reset_sequencer.sv
// Power-up reset sequencer: waits for clock lock, settles, pulses IDELAYCTRL
// reset, waits for its ready flag with bounded retries, then releases user reset.
module sys_reset_sequencer #(
  parameter int LOCK_SETTLE_CYCLES = 1024,
  parameter int IDELAY_RST_CYCLES  = 16,
  parameter int RDY_TIMEOUT        = 4096,
  parameter int MAX_RETRIES        = 3
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       sys_clk_lock,
  input  logic       idelay_rdy,
  input  logic       soft_rst,
  output logic       idelay_rst,
  output logic       user_rst,
  output logic       seq_ready,
  output logic       seq_fail,
  output logic [2:0] seq_state,
  output logic [1:0] retry_cnt,
  output logic [7:0] lock_loss_cnt
);

  localparam int MAX_AB  = (LOCK_SETTLE_CYCLES > IDELAY_RST_CYCLES) ? LOCK_SETTLE_CYCLES
                                                                    : IDELAY_RST_CYCLES;
  localparam int MAX_CYC = (MAX_AB > RDY_TIMEOUT) ? MAX_AB : RDY_TIMEOUT;
  localparam int CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  localparam logic [CW-1:0] SETTLE_LAST  = CW'(LOCK_SETTLE_CYCLES - 1);
  localparam logic [CW-1:0] IDLY_LAST    = CW'(IDELAY_RST_CYCLES - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(RDY_TIMEOUT - 1);

  typedef enum logic [2:0] {
    WAIT_LOCK = 3'd0,
    SETTLE    = 3'd1,
    IDLY_RST  = 3'd2,
    WAIT_RDY  = 3'd3,
    RUN       = 3'd4,
    FAIL      = 3'd5
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          lock_m, lock_s;
  logic          rdy_m, rdy_s;

  // Outputs are a registered copy of the state, so they trail it by one cycle;
  // the retry and lock-loss counters are the live registers themselves.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state         <= WAIT_LOCK;
      cnt           <= '0;
      lock_m        <= 1'b0;
      lock_s        <= 1'b0;
      rdy_m         <= 1'b0;
      rdy_s         <= 1'b0;
      retry_cnt     <= 2'd0;
      lock_loss_cnt <= 8'd0;
      idelay_rst    <= 1'b0;
      user_rst      <= 1'b1;
      seq_ready     <= 1'b0;
      seq_fail      <= 1'b0;
      seq_state     <= 3'd0;
    end else begin
      lock_m     <= sys_clk_lock;
      lock_s     <= lock_m;
      rdy_m      <= idelay_rdy;
      rdy_s      <= rdy_m;
      idelay_rst <= (state == IDLY_RST);
      user_rst   <= (state != RUN);
      seq_ready  <= (state == RUN);
      seq_fail   <= (state == FAIL);
      seq_state  <= state;

      case (state)
        WAIT_LOCK: begin
          if (lock_s) begin
            state <= SETTLE;
            cnt   <= '0;
          end
        end
        FAIL: begin
          if (soft_rst) begin
            state     <= IDLY_RST;
            cnt       <= '0;
            retry_cnt <= 2'd0;
          end
        end
        default: begin
          // Lock loss outranks a software restart in the same cycle.
          if (!lock_s) begin
            state     <= WAIT_LOCK;
            cnt       <= '0;
            retry_cnt <= 2'd0;
            if (lock_loss_cnt != 8'hFF) lock_loss_cnt <= lock_loss_cnt + 8'd1;
          end else if (soft_rst) begin
            state     <= IDLY_RST;
            cnt       <= '0;
            retry_cnt <= 2'd0;
          end else begin
            case (state)
              SETTLE: begin
                if (cnt == SETTLE_LAST) begin
                  state <= IDLY_RST;
                  cnt   <= '0;
                end else begin
                  cnt <= cnt + CW'(1);
                end
              end
              IDLY_RST: begin
                if (cnt == IDLY_LAST) begin
                  state <= WAIT_RDY;
                  cnt   <= '0;
                end else begin
                  cnt <= cnt + CW'(1);
                end
              end
              WAIT_RDY: begin
                if (rdy_s) begin
                  state <= RUN;
                  cnt   <= '0;
                end else if (cnt == TIMEOUT_LAST) begin
                  cnt <= '0;
                  if (int'(retry_cnt) < MAX_RETRIES) begin
                    retry_cnt <= retry_cnt + 2'd1;
                    state     <= IDLY_RST;
                  end else begin
                    state <= FAIL;
                  end
                end else begin
                  cnt <= cnt + CW'(1);
                end
              end
              RUN: ;
              default: begin
                state <= WAIT_LOCK;
                cnt   <= '0;
              end
            endcase
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sys_reset_sequencer.sv
// Bench for sys_reset_sequencer: per-cycle scoreboard against a phase-level
// reference model, plus directed scenarios for the bring-up corner cases.
module tb_sys_reset_sequencer;

  localparam int LSC = 8;
  localparam int IRC = 4;
  localparam int RTO = 16;
  localparam int MR  = 2;

  localparam int S_WL = 0, S_SET = 1, S_IDR = 2, S_WRDY = 3, S_RUN = 4, S_FAIL = 5;

  logic       sys_clk = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic       sys_clk_lock = 1'b0;
  logic       idelay_rdy = 1'b0;
  logic       soft_rst = 1'b0;
  logic       idelay_rst, user_rst, seq_ready, seq_fail;
  logic [2:0] seq_state;
  logic [1:0] retry_cnt;
  logic [7:0] lock_loss_cnt;

  sys_reset_sequencer #(
    .LOCK_SETTLE_CYCLES(LSC),
    .IDELAY_RST_CYCLES (IRC),
    .RDY_TIMEOUT       (RTO),
    .MAX_RETRIES       (MR)
  ) dut (
    .sys_clk      (sys_clk),
    .sys_rst_n    (sys_rst_n),
    .sys_clk_lock (sys_clk_lock),
    .idelay_rdy   (idelay_rdy),
    .soft_rst     (soft_rst),
    .idelay_rst   (idelay_rst),
    .user_rst     (user_rst),
    .seq_ready    (seq_ready),
    .seq_fail     (seq_fail),
    .seq_state    (seq_state),
    .retry_cnt    (retry_cnt),
    .lock_loss_cnt(lock_loss_cnt)
  );

  // ---------------- clock ----------------
  always #5 sys_clk = ~sys_clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [16:0] exp_q[$];

  // ---------------- reference model ----------------
  // Sync pipelines are two-entry delay lines; m_cnt is cycles spent in the phase.
  int m_lm = 0, m_ls = 0, m_rm = 0, m_rs = 0;
  int m_st = S_WL, m_cnt = 0, m_retry = 0, m_llc = 0;
  logic [16:0] m_out;

  task automatic enter(input int s);
    m_st  = s;
    m_cnt = 0;
  endtask

  task automatic model_edge();
    int shown, lk, rd;
    shown = m_st;
    lk    = m_ls;
    rd    = m_rs;
    if (!sys_rst_n) begin
      m_lm = 0; m_ls = 0; m_rm = 0; m_rs = 0;
      m_st = S_WL; m_cnt = 0; m_retry = 0; m_llc = 0;
      m_out = {1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 2'd0, 8'd0};
      return;
    end
    m_ls = m_lm; m_lm = int'(sys_clk_lock);
    m_rs = m_rm; m_rm = int'(idelay_rdy);
    if (m_st == S_WL) begin
      if (lk != 0) enter(S_SET);
    end else if (m_st == S_FAIL) begin
      if (soft_rst) begin m_retry = 0; enter(S_IDR); end
    end else if (lk == 0) begin
      m_retry = 0;
      m_llc   = (m_llc < 255) ? m_llc + 1 : 255;
      enter(S_WL);
    end else if (soft_rst) begin
      m_retry = 0;
      enter(S_IDR);
    end else begin
      m_cnt++;
      case (m_st)
        S_SET:  if (m_cnt == LSC) enter(S_IDR);
        S_IDR:  if (m_cnt == IRC) enter(S_WRDY);
        S_WRDY: begin
          if (rd != 0) enter(S_RUN);
          else if (m_cnt == RTO) begin
            if (m_retry < MR) begin m_retry++; enter(S_IDR); end
            else enter(S_FAIL);
          end
        end
        default: ;
      endcase
    end
    m_out = {shown == S_IDR, shown != S_RUN, shown == S_RUN, shown == S_FAIL,
             3'(shown), 2'(m_retry), 8'(m_llc)};
  endtask

  // ---------------- driver ----------------
  task automatic step();
    @(posedge sys_clk);
    model_edge();
    exp_q.push_back(m_out);
    cyc++;
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%0d expected=%0d", name, cyc, act, exp);
    end
  endtask

  task automatic wait_state(input int s, input int limit, input string name);
    int n;
    n = 0;
    while (int'(seq_state) != s && n < limit) begin
      step();
      n++;
    end
    check(name, int'(seq_state), s);
  endtask

  // ---------------- scoreboard monitor ----------------
  initial begin
    logic [16:0] exp, act;
    forever begin
      @(negedge sys_clk);
      if (exp_q.size() > 0) begin
        exp = exp_q.pop_front();
        act = {idelay_rst, user_rst, seq_ready, seq_fail, seq_state, retry_cnt, lock_loss_cnt};
        checks++;
        if (act !== exp) begin
          errors++;
          $display("FAIL outputs cyc=%0d actual=%h expected=%h", cyc, act, exp);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int width, pulses, n;
    logic prev;

    // Reset state
    repeat (3) step();
    check("reset_idelay_rst", int'(idelay_rst), 0);
    check("reset_user_rst", int'(user_rst), 1);
    check("reset_seq_state", int'(seq_state), 0);
    check("reset_lock_loss", int'(lock_loss_cnt), 0);
    sys_rst_n = 1'b1;

    // Nominal bring-up
    sys_clk_lock = 1'b1;
    width = 0; prev = 1'b0; n = 0;
    while (n < 60) begin
      step();
      n++;
      if (idelay_rst) width++;
      if (prev && !idelay_rst) break;
      prev = idelay_rst;
    end
    check("nominal_pulse_width", width, IRC);
    idelay_rdy = 1'b1;
    wait_state(S_RUN, 12, "nominal_run_state");
    check("nominal_user_rst", int'(user_rst), 0);
    check("nominal_seq_ready", int'(seq_ready), 1);

    // Single-cycle lock loss in RUN, then full re-sequence
    sys_clk_lock = 1'b0;
    step();
    sys_clk_lock = 1'b1;
    wait_state(S_WL, 8, "lockloss_state");
    check("lockloss_user_rst", int'(user_rst), 1);
    check("lockloss_count", int'(lock_loss_cnt), 1);
    wait_state(S_RUN, 60, "relock_run_state");

    // Timeout path: three pulses then FAIL
    idelay_rdy = 1'b0;
    repeat (3) step();
    soft_rst = 1'b1;
    step();
    soft_rst = 1'b0;
    pulses = 0; prev = idelay_rst; n = 0;
    while (!seq_fail && n < 200) begin
      step();
      n++;
      if (idelay_rst && !prev) begin
        pulses++;
        check("timeout_retry_at_pulse", int'(retry_cnt), pulses - 1);
      end
      prev = idelay_rst;
    end
    check("timeout_pulses", pulses, MR + 1);
    check("timeout_seq_fail", int'(seq_fail), 1);
    check("timeout_seq_state", int'(seq_state), S_FAIL);
    check("timeout_user_rst", int'(user_rst), 1);
    check("timeout_retry_final", int'(retry_cnt), MR);

    // Lock loss must not leave FAIL
    sys_clk_lock = 1'b0;
    repeat (5) step();
    sys_clk_lock = 1'b1;
    repeat (3) step();
    check("fail_holds_state", int'(seq_state), S_FAIL);
    check("fail_no_lockloss_count", int'(lock_loss_cnt), 1);

    // soft_rst in FAIL, then sys reset during IDLY_RST
    soft_rst = 1'b1;
    step();
    soft_rst = 1'b0;
    wait_state(S_IDR, 4, "fail_soft_idly_state");
    check("fail_soft_retry", int'(retry_cnt), 0);
    sys_rst_n = 1'b0;
    step();
    check("midreset_idelay_rst", int'(idelay_rst), 0);
    check("midreset_user_rst", int'(user_rst), 1);
    check("midreset_seq_state", int'(seq_state), 0);
    check("midreset_ready_fail", int'({seq_ready, seq_fail}), 0);
    check("midreset_counts", int'({retry_cnt, lock_loss_cnt}), 0);
    step();
    sys_rst_n = 1'b1;

    // Lock loss and soft_rst on the same edge in WAIT_RDY
    wait_state(S_WRDY, 60, "collide_wait_rdy");
    sys_clk_lock = 1'b0;
    step();
    step();
    soft_rst = 1'b1;
    step();
    soft_rst = 1'b0;
    step();
    check("collide_state", int'(seq_state), S_WL);
    check("collide_idelay_rst", int'(idelay_rst), 0);
    check("collide_lockloss", int'(lock_loss_cnt), 1);

    // Randomized traffic, scoreboard only
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 19) == 0) sys_clk_lock = ~sys_clk_lock;
      if ($urandom_range(0, 9) == 0) idelay_rdy = ~idelay_rdy;
      soft_rst  = ($urandom_range(0, 29) == 0);
      sys_rst_n = ($urandom_range(0, 249) != 0);
      step();
    end
    soft_rst  = 1'b0;
    sys_rst_n = 1'b1;

    // Lock-loss counter saturation
    sys_rst_n = 1'b0;
    sys_clk_lock = 1'b0;
    step();
    sys_rst_n = 1'b1;
    for (int i = 0; i < 300; i++) begin
      sys_clk_lock = 1'b1;
      repeat (4) step();
      sys_clk_lock = 1'b0;
      repeat (3) step();
    end
    repeat (2) step();
    check("saturate_lockloss", int'(lock_loss_cnt), 255);

    repeat (2) @(negedge sys_clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
